// File: rtl/gain_ramp_if.sv
// Host-side control and amplifier-side status bundle for the gain ramp stage.
// The host owns strobes/targets/mute; the ramp owns gain, busy, done and its debug state.
interface gain_ramp_if;
   logic       sample_strobe;
   logic       sample_sign;
   logic [3:0] target_gain;
   logic       target_valid;
   logic       mute;
   logic [3:0] gain;
   logic       busy;
   logic       done;
   logic [1:0] dbg_state;

   // No valid/ready handshake: target_valid and sample_strobe are single-cycle
   // qualifiers that are always accepted; done is a one-cycle completion pulse.
   modport master (
      output sample_strobe, sample_sign, target_gain, target_valid, mute,
      input  gain, busy, done, dbg_state
   );

   modport slave (
      input  sample_strobe, sample_sign, target_gain, target_valid, mute,
      output gain, busy, done, dbg_state
   );
endinterface

// File: rtl/gain_ramp.sv
// Rate-limited 4-bit gain ramp: steps the amplifier gain code one LSB at a time toward
// the (possibly muted) target, optionally deferring each step to an audio zero crossing.
module gain_ramp #(
   parameter int STEP_SAMPLES = 64,
   parameter int ZERO_CROSS   = 1,
   parameter int ZC_TIMEOUT   = 256
) (
   input logic         clk,
   input logic         reset,
   gain_ramp_if.slave  bus
);
   localparam int SW = $clog2(STEP_SAMPLES + 1);
   localparam int TW = $clog2(ZC_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      ARM   = 2'd2
   } state_t;

   state_t        r_state;
   logic [3:0]    r_gain;
   logic [3:0]    r_target;
   logic [SW-1:0] r_step_cnt;
   logic [TW-1:0] r_zc_cnt;
   logic          r_prev_sign;
   logic          r_done;

   logic [3:0]    w_eff;
   logic          w_match;
   logic          w_up;
   logic [3:0]    w_next;
   logic          w_step_end;
   logic          w_take;

   assign w_eff      = bus.mute ? 4'b1000 : r_target;
   assign w_match    = (r_gain == w_eff);
   assign w_up       = ($signed(w_eff) > $signed(r_gain));
   assign w_next     = w_up ? (r_gain + 4'd1) : (r_gain - 4'd1);
   assign w_step_end = (r_step_cnt == SW'(STEP_SAMPLES - 1));

   // A step is only ever taken while gain differs from the effective target, so w_next never wraps.
   always_comb begin
      w_take = 1'b0;
      case (r_state)
         COUNT:   w_take = bus.sample_strobe && w_step_end && (ZERO_CROSS == 0);
         ARM:     w_take = bus.sample_strobe &&
                           ((bus.sample_sign != r_prev_sign) || (r_zc_cnt == TW'(ZC_TIMEOUT - 1)));
         default: w_take = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_gain      <= 4'b1000;
         r_target    <= 4'b1000;
         r_step_cnt  <= '0;
         r_zc_cnt    <= '0;
         r_prev_sign <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.target_valid) r_target <= bus.target_gain;
         if (bus.sample_strobe) r_prev_sign <= bus.sample_sign;

         case (r_state)
            IDLE: begin
               r_step_cnt <= '0;
               r_zc_cnt   <= '0;
               if (!w_match) r_state <= COUNT;
            end
            COUNT, ARM: begin
               if (w_match) begin
                  r_state    <= IDLE;
                  r_done     <= 1'b1;
                  r_step_cnt <= '0;
                  r_zc_cnt   <= '0;
               end else if (w_take) begin
                  r_gain     <= w_next;
                  r_step_cnt <= '0;
                  r_zc_cnt   <= '0;
                  if (w_next == w_eff) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= COUNT;
                  end
               end else if (bus.sample_strobe) begin
                  if (r_state == ARM) begin
                     r_zc_cnt <= r_zc_cnt + TW'(1);
                  end else if (w_step_end) begin
                     r_state    <= ARM;
                     r_step_cnt <= '0;
                     r_zc_cnt   <= '0;
                  end else begin
                     r_step_cnt <= r_step_cnt + SW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gain      = r_gain;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = r_done;
   assign bus.dbg_state = r_state;
endmodule
